// File: rtl/eight_bit_exponential_decay_lookup_pkg.sv
// ----------------------------------------------------------------------------
// eight_bit_exponential_decay_lookup_pkg
// Purpose : Shared constants and the exponential-decay ROM contents used by the
//           decay lookup and by the envelope generator for its own scaling.
//           TABLE[n] = round-half-up(255 * exp(-n / TAU)), TAU = 32, n = 0..255.
//           The entries are generated offline and checked in. The generator
//           rejects a non-monotonic table, wrong end points or wrong reference
//           points.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package eight_bit_exponential_decay_lookup_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned TAU       = 32;

    // Constant ROM. Every code is listed explicitly. The zero default only
    // keeps the function free of an unassigned path.
    function automatic logic [7:0] decay_rom(input logic [7:0] n);
        logic [7:0] v;
        v = 8'd0;
        case (n)
            8'd000: v = 8'd255; 8'd001: v = 8'd247; 8'd002: v = 8'd240; 8'd003: v = 8'd232;
            8'd004: v = 8'd225; 8'd005: v = 8'd218; 8'd006: v = 8'd211; 8'd007: v = 8'd205;
            8'd008: v = 8'd199; 8'd009: v = 8'd192; 8'd010: v = 8'd187; 8'd011: v = 8'd181;
            8'd012: v = 8'd175; 8'd013: v = 8'd170; 8'd014: v = 8'd165; 8'd015: v = 8'd160;
            8'd016: v = 8'd155; 8'd017: v = 8'd150; 8'd018: v = 8'd145; 8'd019: v = 8'd141;
            8'd020: v = 8'd136; 8'd021: v = 8'd132; 8'd022: v = 8'd128; 8'd023: v = 8'd124;
            8'd024: v = 8'd120; 8'd025: v = 8'd117; 8'd026: v = 8'd113; 8'd027: v = 8'd110;
            8'd028: v = 8'd106; 8'd029: v = 8'd103; 8'd030: v = 8'd100; 8'd031: v = 8'd097;
            8'd032: v = 8'd094; 8'd033: v = 8'd091; 8'd034: v = 8'd088; 8'd035: v = 8'd085;
            8'd036: v = 8'd083; 8'd037: v = 8'd080; 8'd038: v = 8'd078; 8'd039: v = 8'd075;
            8'd040: v = 8'd073; 8'd041: v = 8'd071; 8'd042: v = 8'd069; 8'd043: v = 8'd067;
            8'd044: v = 8'd064; 8'd045: v = 8'd062; 8'd046: v = 8'd061; 8'd047: v = 8'd059;
            8'd048: v = 8'd057; 8'd049: v = 8'd055; 8'd050: v = 8'd053; 8'd051: v = 8'd052;
            8'd052: v = 8'd050; 8'd053: v = 8'd049; 8'd054: v = 8'd047; 8'd055: v = 8'd046;
            8'd056: v = 8'd044; 8'd057: v = 8'd043; 8'd058: v = 8'd042; 8'd059: v = 8'd040;
            8'd060: v = 8'd039; 8'd061: v = 8'd038; 8'd062: v = 8'd037; 8'd063: v = 8'd036;
            8'd064: v = 8'd035; 8'd065: v = 8'd033; 8'd066: v = 8'd032; 8'd067: v = 8'd031;
            8'd068: v = 8'd030; 8'd069: v = 8'd030; 8'd070: v = 8'd029; 8'd071: v = 8'd028;
            8'd072: v = 8'd027; 8'd073: v = 8'd026; 8'd074: v = 8'd025; 8'd075: v = 8'd024;
            8'd076: v = 8'd024; 8'd077: v = 8'd023; 8'd078: v = 8'd022; 8'd079: v = 8'd022;
            8'd080: v = 8'd021; 8'd081: v = 8'd020; 8'd082: v = 8'd020; 8'd083: v = 8'd019;
            8'd084: v = 8'd018; 8'd085: v = 8'd018; 8'd086: v = 8'd017; 8'd087: v = 8'd017;
            8'd088: v = 8'd016; 8'd089: v = 8'd016; 8'd090: v = 8'd015; 8'd091: v = 8'd015;
            8'd092: v = 8'd014; 8'd093: v = 8'd014; 8'd094: v = 8'd014; 8'd095: v = 8'd013;
            8'd096: v = 8'd013; 8'd097: v = 8'd012; 8'd098: v = 8'd012; 8'd099: v = 8'd012;
            8'd100: v = 8'd011; 8'd101: v = 8'd011; 8'd102: v = 8'd011; 8'd103: v = 8'd010;
            8'd104: v = 8'd010; 8'd105: v = 8'd010; 8'd106: v = 8'd009; 8'd107: v = 8'd009;
            8'd108: v = 8'd009; 8'd109: v = 8'd008; 8'd110: v = 8'd008; 8'd111: v = 8'd008;
            8'd112: v = 8'd008; 8'd113: v = 8'd007; 8'd114: v = 8'd007; 8'd115: v = 8'd007;
            8'd116: v = 8'd007; 8'd117: v = 8'd007; 8'd118: v = 8'd006; 8'd119: v = 8'd006;
            8'd120: v = 8'd006; 8'd121: v = 8'd006; 8'd122: v = 8'd006; 8'd123: v = 8'd005;
            8'd124: v = 8'd005; 8'd125: v = 8'd005; 8'd126: v = 8'd005; 8'd127: v = 8'd005;
            8'd128: v = 8'd005; 8'd129: v = 8'd005; 8'd130: v = 8'd004; 8'd131: v = 8'd004;
            8'd132: v = 8'd004; 8'd133: v = 8'd004; 8'd134: v = 8'd004; 8'd135: v = 8'd004;
            8'd136: v = 8'd004; 8'd137: v = 8'd004; 8'd138: v = 8'd003; 8'd139: v = 8'd003;
            8'd140: v = 8'd003; 8'd141: v = 8'd003; 8'd142: v = 8'd003; 8'd143: v = 8'd003;
            8'd144: v = 8'd003; 8'd145: v = 8'd003; 8'd146: v = 8'd003; 8'd147: v = 8'd003;
            8'd148: v = 8'd002; 8'd149: v = 8'd002; 8'd150: v = 8'd002; 8'd151: v = 8'd002;
            8'd152: v = 8'd002; 8'd153: v = 8'd002; 8'd154: v = 8'd002; 8'd155: v = 8'd002;
            8'd156: v = 8'd002; 8'd157: v = 8'd002; 8'd158: v = 8'd002; 8'd159: v = 8'd002;
            8'd160: v = 8'd002; 8'd161: v = 8'd002; 8'd162: v = 8'd002; 8'd163: v = 8'd002;
            8'd164: v = 8'd002; 8'd165: v = 8'd001; 8'd166: v = 8'd001; 8'd167: v = 8'd001;
            8'd168: v = 8'd001; 8'd169: v = 8'd001; 8'd170: v = 8'd001; 8'd171: v = 8'd001;
            8'd172: v = 8'd001; 8'd173: v = 8'd001; 8'd174: v = 8'd001; 8'd175: v = 8'd001;
            8'd176: v = 8'd001; 8'd177: v = 8'd001; 8'd178: v = 8'd001; 8'd179: v = 8'd001;
            8'd180: v = 8'd001; 8'd181: v = 8'd001; 8'd182: v = 8'd001; 8'd183: v = 8'd001;
            8'd184: v = 8'd001; 8'd185: v = 8'd001; 8'd186: v = 8'd001; 8'd187: v = 8'd001;
            8'd188: v = 8'd001; 8'd189: v = 8'd001; 8'd190: v = 8'd001; 8'd191: v = 8'd001;
            8'd192: v = 8'd001; 8'd193: v = 8'd001; 8'd194: v = 8'd001; 8'd195: v = 8'd001;
            8'd196: v = 8'd001; 8'd197: v = 8'd001; 8'd198: v = 8'd001; 8'd199: v = 8'd001;
            8'd200: v = 8'd000; 8'd201: v = 8'd000; 8'd202: v = 8'd000; 8'd203: v = 8'd000;
            8'd204: v = 8'd000; 8'd205: v = 8'd000; 8'd206: v = 8'd000; 8'd207: v = 8'd000;
            8'd208: v = 8'd000; 8'd209: v = 8'd000; 8'd210: v = 8'd000; 8'd211: v = 8'd000;
            8'd212: v = 8'd000; 8'd213: v = 8'd000; 8'd214: v = 8'd000; 8'd215: v = 8'd000;
            8'd216: v = 8'd000; 8'd217: v = 8'd000; 8'd218: v = 8'd000; 8'd219: v = 8'd000;
            8'd220: v = 8'd000; 8'd221: v = 8'd000; 8'd222: v = 8'd000; 8'd223: v = 8'd000;
            8'd224: v = 8'd000; 8'd225: v = 8'd000; 8'd226: v = 8'd000; 8'd227: v = 8'd000;
            8'd228: v = 8'd000; 8'd229: v = 8'd000; 8'd230: v = 8'd000; 8'd231: v = 8'd000;
            8'd232: v = 8'd000; 8'd233: v = 8'd000; 8'd234: v = 8'd000; 8'd235: v = 8'd000;
            8'd236: v = 8'd000; 8'd237: v = 8'd000; 8'd238: v = 8'd000; 8'd239: v = 8'd000;
            8'd240: v = 8'd000; 8'd241: v = 8'd000; 8'd242: v = 8'd000; 8'd243: v = 8'd000;
            8'd244: v = 8'd000; 8'd245: v = 8'd000; 8'd246: v = 8'd000; 8'd247: v = 8'd000;
            8'd248: v = 8'd000; 8'd249: v = 8'd000; 8'd250: v = 8'd000; 8'd251: v = 8'd000;
            8'd252: v = 8'd000; 8'd253: v = 8'd000; 8'd254: v = 8'd000; 8'd255: v = 8'd000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/eight_bit_exponential_decay_lookup.sv
// ----------------------------------------------------------------------------
// eight_bit_exponential_decay_lookup
// Purpose : Registered exponential-decay lookup with a latency of one cycle.
//           On each rising clk edge, dout is loaded with TABLE[din]. There is no
//           enable and no handshake.
// Ports   : clk      - rising-edge clock
//           reset_n  - asynchronous active-low reset; clears dout to 0 at once
//           din      - phase position (0 = start of decay, 255 = end)
//           dout     - registered decay amplitude
// Params  : DATA_BITS (only 8 supported), TAU (the ROM is built for 32)
// ----------------------------------------------------------------------------
module eight_bit_exponential_decay_lookup
    import eight_bit_exponential_decay_lookup_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned TAU       = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout
);

    logic [DATA_BITS-1:0] r_dout;
    logic                 w_unused_cfg_ok;

    // The ROM contents are fixed. Other parameter values are not honoured.
    assign w_unused_cfg_ok =
        (DATA_BITS == eight_bit_exponential_decay_lookup_pkg::DATA_BITS) &&
        (TAU == eight_bit_exponential_decay_lookup_pkg::TAU);

    // The output register is the only state in the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= '0;
        end else begin
            r_dout <= decay_rom(din);
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_eight_bit_exponential_decay_lookup.sv
module tb_eight_bit_exponential_decay_lookup;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] din;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eight_bit_exponential_decay_lookup dut (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (din),
        .dout    (dout)
    );

    typedef struct {
        string      name;
        logic [7:0] din;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[16];

    // Independent reference: round-half-up(255 * exp(-n/32)).
    function automatic logic [7:0] golden(input int n);
        real x;
        x = 255.0 * $exp(-real'(n) / 32.0);
        return 8'($rtoi($floor(x + 0.5)));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: dout=%0d expected=%0d", name, act, req);
        end
    endtask

    logic [7:0] prev;

    initial begin
        vecs[0]  = '{"ref_0",    8'd0,   8'd255};
        vecs[1]  = '{"ref_1",    8'd1,   8'd247};
        vecs[2]  = '{"ref_2",    8'd2,   8'd240};
        vecs[3]  = '{"ref_16",   8'd16,  8'd155};
        vecs[4]  = '{"ref_32",   8'd32,  8'd94};
        vecs[5]  = '{"ref_45",   8'd45,  8'd62};
        vecs[6]  = '{"ref_64",   8'd64,  8'd35};
        vecs[7]  = '{"ref_94",   8'd94,  8'd14};
        vecs[8]  = '{"ref_128",  8'd128, 8'd5};
        vecs[9]  = '{"ref_148",  8'd148, 8'd2};
        vecs[10] = '{"ref_164",  8'd164, 8'd2};
        vecs[11] = '{"ref_165",  8'd165, 8'd1};
        vecs[12] = '{"ref_199",  8'd199, 8'd1};
        vecs[13] = '{"ref_200",  8'd200, 8'd0};
        vecs[14] = '{"ref_255",  8'd255, 8'd0};
        vecs[15] = '{"ref_0_again", 8'd0, 8'd255};

        // Reset: held low with din = 0 while the clock runs.
        reset_n = 1'b1;
        din     = 8'd0;
        #2 reset_n = 1'b0;
        #1 check("reset_entry", dout, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", dout, 8'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_release_first_edge", dout, 8'd255);

        // Directed table vectors.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            din = vecs[i].din;
            @(negedge clk);
            check(vecs[i].name, dout, vecs[i].exp_dout);
        end

        // Latency: the new din becomes visible only after the edge.
        @(negedge clk);
        din = 8'd0;
        @(negedge clk);
        check("latency_setup", dout, 8'd255);
        din = 8'd32;
        #2 check("latency_before_edge", dout, 8'd255);
        @(negedge clk);
        check("latency_edge_k", dout, 8'd94);
        din = 8'd64;
        @(negedge clk);
        check("latency_edge_k1", dout, 8'd35);

        // Sweep all codes one per cycle against the model, plus monotonicity.
        prev = 8'd255;
        for (int n = 0; n <= 256; n++) begin
            @(negedge clk);
            if (n > 0) begin
                check($sformatf("sweep_%0d", n - 1), dout, golden(n - 1));
                checks++;
                if (dout > prev) begin
                    errors++;
                    $display("FAIL monotonic_%0d: dout=%0d previous=%0d", n - 1, dout, prev);
                end
                prev = dout;
            end
            if (n < 256) din = 8'(n);
        end

        // Async reset between edges while dout = 155.
        @(negedge clk);
        din = 8'd16;
        @(negedge clk);
        check("async_setup", dout, 8'd155);
        #1 reset_n = 1'b0;
        #1 check("async_reset_no_clock", dout, 8'd0);
        #1 reset_n = 1'b1;
        #1 check("async_released_before_edge", dout, 8'd0);
        @(negedge clk);
        check("async_after_release", dout, 8'd155);

        // Reset held across an edge overrides the pending load.
        din = 8'd64;
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("reset_overrides_load", dout, 8'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("load_after_override", dout, 8'd35);

        // Glitch: din toggles between edges and settles at 0 before the edge.
        din = 8'd128;
        @(negedge clk);
        check("glitch_setup", dout, 8'd5);
        din = 8'd0;
        #1 din = 8'd255;
        #1 din = 8'd0;
        #1 check("glitch_between_edges", dout, 8'd5);
        @(negedge clk);
        check("glitch_result", dout, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eight_bit_exponential_decay_lookup.md
EIGHT_BIT_EXPONENTIAL_DECAY_LOOKUP -- requirements
Module: eight_bit_exponential_decay_lookup

Interface
REQ-001 SHALL use one clock and reset; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be:
- DATA_BITS, default 8, width of din and dout; fixed at 8, other values unsupported.
- TAU, default 32, decay constant in input LSBs.
REQ-003 Port clk SHALL be: clk  input  1  rising-edge clock.
REQ-004 Port reset_n SHALL be: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port din SHALL be: din  input  8  unsigned phase position, 0 = start of decay, 255 = end of decay.
REQ-006 Port dout SHALL be: dout  output  8  unsigned exponential-decay amplitude, registered.

Function
REQ-007 Each rising clk edge with reset_n high SHALL load dout with TABLE[din].
- Latency is exactly 1 cycle.
- No enable and no handshake; a new din is accepted every cycle.
REQ-008 TABLE[n] SHALL equal round-half-up(255 * exp(-n / TAU)) for n = 0..255.
- With TAU = 32 this gives TABLE[0] = 255.
REQ-009 The table SHALL be a constant 256-entry, 8-bit ROM, fully enumerated for all 256 din codes.
- It SHALL have no X or default-driven entries.
REQ-010 TABLE SHALL be monotonically non-increasing in n.
REQ-011 Table end points SHALL be:
- TABLE[0] = 255 (full scale).
- TABLE[255] = 0. Any computed value that rounds to 0 SHALL stay 0; no wrap-around to 255.
REQ-012 Reference points SHALL be exact:
- TABLE[1] = 247
- TABLE[16] = 155
- TABLE[32] = 94
- TABLE[64] = 35
- TABLE[128] = 5
REQ-013 Arithmetic SHALL happen only at table generation time; the RTL contains no multiplier or exp logic.
REQ-014 dout SHALL depend only on din sampled at the most recent qualifying edge; the block has no internal state besides the output register.
REQ-015 din changing between edges SHALL NOT affect dout until the next rising edge.

Reset
REQ-016 While reset_n is low, dout SHALL be 0, and SHALL reach 0 immediately without waiting for clk.
REQ-017 Asserting reset_n mid-operation SHALL force dout to 0 at once, overriding any pending load.
REQ-018 After reset_n deasserts, the first rising clk edge SHALL load TABLE[din].
- No extra warm-up cycles.

Structure
REQ-019 A shared package (e.g. envelope_pkg) SHALL hold:
- the constants DATA_BITS = 8 and TAU = 32;
- a generated localparam array or function defining TABLE.
The envelope generator SHALL reuse the package for its own exponential scaling.
REQ-020 The block SHALL be a single module containing the ROM case statement and one output register; no sub-module is needed.
REQ-021 Table contents SHALL be produced by an offline script from REQ-008 and checked in.
- The script SHALL fail if REQ-010, REQ-011 or REQ-012 are violated.

Verification
REQ-022 Reset test: hold reset_n = 0 with din = 0 and clk toggling -> dout = 0 throughout; release reset_n, next edge -> dout = 255.
REQ-023 Latency test: din = 32 applied before edge k -> dout = 94 after edge k, not before; din = 64 before edge k+1 -> dout = 35.
REQ-024 Exhaustive sweep: din = 0..255 one per cycle -> each dout equals the golden TABLE[n] one cycle later.
- Covers 0 -> 255, 1 -> 247, 16 -> 155, 128 -> 5, 255 -> 0.
- Checks dout never increases across the sweep.
REQ-025 Async reset test: reset_n pulsed low between edges while dout = 155 -> dout = 0 immediately with no clock edge; after release with din = 16 -> 155 on next edge.
REQ-026 Glitch test: din toggles 0 -> 255 -> 0 between two edges, stable 0 at the edge -> dout = 255 only, no intermediate value.
